// File: rtl/vert_obstacle_mover.sv
// Vertical bar obstacle with a moving pass-through gap, decoded from the VGA raster counters.
// Latency: one clk from hcount/vcount to red/pixel_on; gap_top moves on frame_tick only.
// Backpressure: none; the pixel stream is free-running and motion is gated by run sampled on frame_tick.
//
// Ports:
//   clk, rst_n       pixel clock, asynchronous active-low reset
//   hcount, vcount   current raster column / line (blanking counts 640+/480+ are allowed)
//   frame_tick       one-cycle pulse per frame, expected during vertical blanking
//   run              1 = gap moves on each frame_tick, 0 = gap frozen
//   red              registered colour channel (COLOR while the pixel is on, else 0)
//   pixel_on         registered bar-pixel flag for collision logic
//   gap_top          current first line of the gap
//
// Build option: define VOBST_BOUNCE_EN to make the gap bounce between Y_TOP and GAP_MAX
// instead of wrapping from GAP_MAX back to Y_TOP.

module vert_obstacle_mover #(
  parameter int         X_LEFT   = 308,
  parameter int         BAR_W    = 8,
  parameter int         Y_TOP    = 8,
  parameter int         Y_BOT    = 471,
  parameter int         GAP_H    = 48,
  parameter int         STEP     = 2,
  parameter int         GAP_INIT = 200,
  parameter logic [3:0] COLOR    = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       frame_tick,
  input  logic       run,
  output logic [3:0] red,
  output logic       pixel_on,
  output logic [9:0] gap_top
);

  // Lowest line the gap top may occupy so the gap still ends on Y_BOT.
  localparam int GAP_MAX = Y_BOT - GAP_H + 1;

  // All raster comparisons are done in 11 bits so that gap_top+GAP_H-1 and
  // gap_top+STEP can never wrap around the 10-bit counter range.
  localparam logic [10:0] X_LO    = 11'(X_LEFT);
  localparam logic [10:0] X_HI    = 11'(X_LEFT + BAR_W - 1);
  localparam logic [10:0] Y_LO    = 11'(Y_TOP);
  localparam logic [10:0] Y_HI    = 11'(Y_BOT);
  localparam logic [10:0] GMAX_11 = 11'(GAP_MAX);
  localparam logic [10:0] STEP_11 = 11'(STEP);
  localparam logic [10:0] GAPH_M1 = 11'(GAP_H - 1);

  localparam logic [9:0]  GAP_RST = 10'(GAP_INIT);
  localparam logic [9:0]  YTOP_10 = 10'(Y_TOP);
  localparam logic [9:0]  GMAX_10 = 10'(GAP_MAX);
  localparam logic [9:0]  STEP_10 = 10'(STEP);

  typedef enum logic {
    PAUSED = 1'b0,
    MOVING = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [9:0]  gap_d;
  logic [10:0] gap_sum;

`ifdef VOBST_BOUNCE_EN
  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } dir_t;

  dir_t dir_q;
  dir_t dir_d;
`endif

  assign gap_sum = {1'b0, gap_top} + STEP_11;

  // ---------------------------------------------------------------------------
  // Motion FSM: run is only looked at on frame_tick, and the tick that enters
  // MOVING already moves the gap (the decision uses the resulting state).
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    gap_d   = gap_top;
`ifdef VOBST_BOUNCE_EN
    dir_d   = dir_q;
`endif
    if (frame_tick) begin
      state_d = run ? MOVING : PAUSED;
      if (state_d == MOVING) begin
`ifdef VOBST_BOUNCE_EN
        if (dir_q == DOWN) begin
          // Clamp onto the bottom stop and turn around there.
          if (gap_sum > GMAX_11) begin
            gap_d = GMAX_10;
            dir_d = UP;
          end else begin
            gap_d = gap_sum[9:0];
          end
        end else begin
          // Compare before subtracting so the 10-bit difference cannot underflow.
          if ({1'b0, gap_top} < (Y_LO + STEP_11)) begin
            gap_d = YTOP_10;
            dir_d = DOWN;
          end else begin
            gap_d = gap_top - STEP_10;
          end
        end
`else
        gap_d = (gap_sum > GMAX_11) ? YTOP_10 : gap_sum[9:0];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PAUSED;
      gap_top <= GAP_RST;
    end else begin
      state_q <= state_d;
      gap_top <= gap_d;
    end
  end

`ifdef VOBST_BOUNCE_EN
  // Direction survives PAUSED so a resumed gap keeps heading the same way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= DOWN;
    end else begin
      dir_q <= dir_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Pixel decode. gap_top only changes during blanking, so using the live
  // register here never tears the visible frame.
  // ---------------------------------------------------------------------------
  logic [10:0] h_11;
  logic [10:0] v_11;
  logic [10:0] gap_11;
  logic        in_bar;
  logic        in_gap;
  logic        on;

  assign h_11   = {1'b0, hcount};
  assign v_11   = {1'b0, vcount};
  assign gap_11 = {1'b0, gap_top};

  assign in_bar = (h_11 >= X_LO) && (h_11 <= X_HI) && (v_11 >= Y_LO) && (v_11 <= Y_HI);
  assign in_gap = (v_11 >= gap_11) && (v_11 <= (gap_11 + GAPH_M1));
  assign on     = in_bar && !in_gap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red      <= 4'h0;
      pixel_on <= 1'b0;
    end else begin
      red      <= on ? COLOR : 4'h0;
      pixel_on <= on;
    end
  end

endmodule
